// File: rtl/aes_wddl_pkg.sv
// Shared types for the WDDL final-round unload path: FSM states, column geometry,
// and a column-select helper (col 0 is the most significant word).
package aes_wddl_pkg;

  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;
  localparam int BLK_W    = COL_W * NUM_COLS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef logic [1:0] col_t;

  function automatic logic [COL_W-1:0] col_slice(input logic [BLK_W-1:0] blk,
                                                 input col_t col);
    logic [COL_W-1:0] s;
    case (col)
      2'd0:    s = blk[127:96];
      2'd1:    s = blk[95:64];
      2'd2:    s = blk[63:32];
      default: s = blk[31:0];
    endcase
    return s;
  endfunction

endpackage

// File: rtl/aes_final_xor_wddl_if.sv
// Unload bus for the final AddRoundKey: dual-rail state/key in, dual-rail ciphertext out
// with a valid/ack hold until the consumer takes the block.
interface aes_final_xor_wddl_if;
  import aes_wddl_pkg::*;

  logic             start;
  logic [BLK_W-1:0] sa_i;
  logic [BLK_W-1:0] sa_i_n;
  logic [BLK_W-1:0] w_i;
  logic [BLK_W-1:0] w_i_n;
  logic             busy;
  logic [BLK_W-1:0] text_out;
  logic [BLK_W-1:0] text_out_n;
  logic             out_valid;
  logic             out_ack;
  logic             rail_err;

  modport master (
    output start, sa_i, sa_i_n, w_i, w_i_n, out_ack,
    input  busy, text_out, text_out_n, out_valid, rail_err
  );

  modport slave (
    input  start, sa_i, sa_i_n, w_i, w_i_n, out_ack,
    output busy, text_out, text_out_n, out_valid, rail_err
  );

endinterface

// File: rtl/wddl_xor2.sv
// Single-bit WDDL dual-rail XOR: precharge inputs (0/0) give a 0/0 output,
// valid complementary inputs give a complementary result.
module wddl_xor2 (
  input  logic a,
  input  logic a_n,
  input  logic b,
  input  logic b_n,
  output logic z,
  output logic z_n
);

  assign z   = (a & b_n) | (a_n & b);
  assign z_n = (a & b)   | (a_n & b_n);

endmodule

// File: rtl/aes_final_xor_wddl.sv
// Final AddRoundKey over dual rails, one 32-bit column per precharge/evaluate pair;
// result valid 4*(PRE_CYCLES+1) edges after start and held until out_ack.
module aes_final_xor_wddl
  import aes_wddl_pkg::*;
#(
  parameter int PRE_CYCLES = 1,
  parameter int RAIL_CHECK = 1
) (
  input logic                clk,
  input logic                rst,
  aes_final_xor_wddl_if.slave bus
);

  localparam logic [1:0] PRE_LAST = 2'(PRE_CYCLES - 1);

  state_t           state;
  col_t             col;
  logic [1:0]       pre_cnt;
  logic [BLK_W-1:0] sa_q, sa_n_q, w_q, w_n_q;
  logic [BLK_W-1:0] text_q, text_n_q;
  logic             busy_q, valid_q, err_q;

  logic [COL_W-1:0] op_a, op_a_n, op_b, op_b_n;
  logic [COL_W-1:0] xo, xo_n;
  logic             col_viol;

  // Operands sit at precharge (0/0) everywhere except the single evaluate cycle.
  always_comb begin
    op_a   = '0;
    op_a_n = '0;
    op_b   = '0;
    op_b_n = '0;
    if (state == EVAL) begin
      op_a   = col_slice(sa_q, col);
      op_a_n = col_slice(sa_n_q, col);
      op_b   = col_slice(w_q, col);
      op_b_n = col_slice(w_n_q, col);
    end
  end

  for (genvar i = 0; i < COL_W; i++) begin : g_xor
    wddl_xor2 u_xor (
      .a   (op_a[i]),
      .a_n (op_a_n[i]),
      .b   (op_b[i]),
      .b_n (op_b_n[i]),
      .z   (xo[i]),
      .z_n (xo_n[i])
    );
  end

  assign col_viol = (RAIL_CHECK != 0) &&
                    ((|(~(op_a ^ op_a_n))) || (|(~(op_b ^ op_b_n))));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col      <= '0;
      pre_cnt  <= '0;
      sa_q     <= '0;
      sa_n_q   <= '0;
      w_q      <= '0;
      w_n_q    <= '0;
      text_q   <= '0;
      text_n_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa_q     <= bus.sa_i;
            sa_n_q   <= bus.sa_i_n;
            w_q      <= bus.w_i;
            w_n_q    <= bus.w_i_n;
            col      <= '0;
            pre_cnt  <= '0;
            err_q    <= 1'b0;
            text_q   <= '0;
            text_n_q <= '0;
            busy_q   <= 1'b1;
            state    <= PRE;
          end
        end
        PRE: begin
          if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            state   <= EVAL;
          end else begin
            pre_cnt <= pre_cnt + 2'd1;
          end
        end
        EVAL: begin
          case (col)
            2'd0: begin text_q[127:96] <= xo; text_n_q[127:96] <= xo_n; end
            2'd1: begin text_q[95:64]  <= xo; text_n_q[95:64]  <= xo_n; end
            2'd2: begin text_q[63:32]  <= xo; text_n_q[63:32]  <= xo_n; end
            default: begin text_q[31:0] <= xo; text_n_q[31:0] <= xo_n; end
          endcase
          if (col_viol) begin
            err_q <= 1'b1;
          end
          if (col == 2'd3) begin
            valid_q <= 1'b1;
            state   <= OUT;
          end else begin
            col   <= col + 2'd1;
            state <= PRE;
          end
        end
        OUT: begin
          // Ack returns the output rails to precharge before the next block.
          if (bus.out_ack) begin
            text_q   <= '0;
            text_n_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.out_valid  = valid_q;
  assign bus.rail_err   = err_q;
  assign bus.text_out   = text_q;
  assign bus.text_out_n = text_n_q;

endmodule

// File: tb/tb_aes_final_xor_wddl.sv
// Scoreboarded bench: two instances (PRE_CYCLES 1 and 3) exercised one scenario per task.
module tb_aes_final_xor_wddl;
  import aes_wddl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_final_xor_wddl_if bus1 ();
  aes_final_xor_wddl_if bus3 ();

  aes_final_xor_wddl #(.PRE_CYCLES(1), .RAIL_CHECK(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  aes_final_xor_wddl #(.PRE_CYCLES(3), .RAIL_CHECK(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  localparam logic [127:0] FIPS_SA = 128'he9317db5cb322c723d2e895faf090794;
  localparam logic [127:0] FIPS_W  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_t_q[$];
  logic [127:0] exp_n_q[$];

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] done_mask(input int ncols);
    logic [127:0] m;
    m = '0;
    for (int c = 0; c < ncols; c++) m[127-32*c -: 32] = '1;
    return m;
  endfunction

  // All driving tasks are entered and left at a negedge.
  task automatic drive_start1(input logic [127:0] sa, san, w, wn, et, en);
    bus1.sa_i = sa; bus1.sa_i_n = san; bus1.w_i = w; bus1.w_i_n = wn;
    bus1.start = 1'b1;
    exp_t_q.push_back(et);
    exp_n_q.push_back(en);
    @(posedge clk); @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic wait_valid1(output int n);
    n = 0;
    while (bus1.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_exp(output logic [127:0] et, output logic [127:0] en);
    if (exp_t_q.size() > 0) begin
      et = exp_t_q.pop_front();
      en = exp_n_q.pop_front();
    end else begin
      et = 'x;
      en = 'x;
    end
  endtask

  task automatic ack1();
    bus1.out_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus1.out_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({bus1.busy, bus1.out_valid, bus1.rail_err, bus1.text_out, bus1.text_out_n} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut1: busy=%b vld=%b err=%b t=%h tn=%h, want all 0",
               bus1.busy, bus1.out_valid, bus1.rail_err, bus1.text_out, bus1.text_out_n);
    end
    vectors++;
    if ({bus3.busy, bus3.out_valid, bus3.rail_err, bus3.text_out, bus3.text_out_n} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut3: busy=%b vld=%b err=%b t=%h tn=%h, want all 0",
               bus3.busy, bus3.out_valid, bus3.rail_err, bus3.text_out, bus3.text_out_n);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    int n;
    logic [127:0] et, en;
    drive_start1(FIPS_SA, ~FIPS_SA, FIPS_W, ~FIPS_W, FIPS_CT, ~FIPS_CT);
    vectors++;
    if (bus1.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fips_busy: got %b want 1", bus1.busy);
    end
    wait_valid1(n);
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL fips_latency: got %0d edges want 8", n);
    end
    pop_exp(et, en);
    vectors++;
    if (bus1.text_out !== et || bus1.text_out_n !== en) begin
      miscompares++;
      $display("FAIL fips_data: got %h/%h want %h/%h", bus1.text_out, bus1.text_out_n, et, en);
    end
    vectors++;
    if (bus1.rail_err !== 1'b0) begin
      miscompares++;
      $display("FAIL fips_rail_err: got %b want 0", bus1.rail_err);
    end
    ack1();
    vectors++;
    if ({bus1.busy, bus1.out_valid, bus1.text_out, bus1.text_out_n} !== '0) begin
      miscompares++;
      $display("FAIL fips_after_ack: busy=%b vld=%b t=%h tn=%h want all 0",
               bus1.busy, bus1.out_valid, bus1.text_out, bus1.text_out_n);
    end
  endtask

  task automatic test_pre3();
    logic [127:0] et, en, m;
    bus3.sa_i = FIPS_SA; bus3.sa_i_n = ~FIPS_SA; bus3.w_i = FIPS_W; bus3.w_i_n = ~FIPS_W;
    bus3.start = 1'b1;
    exp_t_q.push_back(FIPS_CT);
    exp_n_q.push_back(~FIPS_CT);
    @(posedge clk); @(negedge clk);
    bus3.start = 1'b0;
    et = exp_t_q[0];
    en = exp_n_q[0];
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      m = done_mask(k / 4);
      vectors++;
      if (bus3.text_out !== (et & m) || bus3.text_out_n !== (en & m) ||
          bus3.out_valid !== (k == 16)) begin
        miscompares++;
        $display("FAIL pre3_snap%0d: got %h/%h vld=%b want %h/%h vld=%b", k,
                 bus3.text_out, bus3.text_out_n, bus3.out_valid, et & m, en & m, k == 16);
      end
    end
    pop_exp(et, en);
    vectors++;
    if (bus3.text_out !== et || bus3.text_out_n !== en) begin
      miscompares++;
      $display("FAIL pre3_data: got %h/%h want %h/%h", bus3.text_out, bus3.text_out_n, et, en);
    end
    bus3.out_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus3.out_ack = 1'b0;
    vectors++;
    if ({bus3.busy, bus3.out_valid, bus3.text_out, bus3.text_out_n} !== '0) begin
      miscompares++;
      $display("FAIL pre3_after_ack: busy=%b vld=%b t=%h tn=%h want all 0",
               bus3.busy, bus3.out_valid, bus3.text_out, bus3.text_out_n);
    end
  endtask

  task automatic test_hold();
    int n;
    logic [127:0] sa, w, et, en;
    sa = rnd128(); w = rnd128();
    drive_start1(sa, ~sa, w, ~w, sa ^ w, ~(sa ^ w));
    wait_valid1(n);
    pop_exp(et, en);
    for (int k = 0; k < 20; k++) begin
      // A start with fresh operands mid-hold must not recapture.
      bus1.start = (k == 5 || k == 6);
      bus1.sa_i  = rnd128();
      bus1.sa_i_n = ~bus1.sa_i;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (bus1.text_out !== et || bus1.text_out_n !== en || bus1.out_valid !== 1'b1 ||
          bus1.busy !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got %h/%h vld=%b busy=%b want %h/%h vld=1 busy=1", k,
                 bus1.text_out, bus1.text_out_n, bus1.out_valid, bus1.busy, et, en);
      end
    end
    bus1.start = 1'b0;
    ack1();
    vectors++;
    if ({bus1.busy, bus1.out_valid, bus1.text_out, bus1.text_out_n} !== '0) begin
      miscompares++;
      $display("FAIL hold_after_ack: busy=%b vld=%b t=%h tn=%h want all 0",
               bus1.busy, bus1.out_valid, bus1.text_out, bus1.text_out_n);
    end
  endtask

  task automatic test_rail_err();
    int n;
    logic [127:0] sa, san, w, et, en;
    sa = rnd128(); w = rnd128();
    san = ~sa;
    sa[70] = 1'b1; san[70] = 1'b1;
    et = sa ^ w;    et[70] = 1'b1;
    en = ~(sa ^ w); en[70] = 1'b1;
    drive_start1(sa, san, w, ~w, et, en);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (bus1.rail_err !== (k >= 4) || bus1.out_valid !== (k == 8)) begin
        miscompares++;
        $display("FAIL rail_err_edge%0d: err=%b vld=%b want err=%b vld=%b", k,
                 bus1.rail_err, bus1.out_valid, k >= 4, k == 8);
      end
    end
    pop_exp(et, en);
    vectors++;
    if (bus1.text_out !== et || bus1.text_out_n !== en) begin
      miscompares++;
      $display("FAIL rail_err_data: got %h/%h want %h/%h", bus1.text_out, bus1.text_out_n, et, en);
    end
    ack1();
    vectors++;
    if (bus1.rail_err !== 1'b1 || bus1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rail_err_sticky: err=%b busy=%b want err=1 busy=0", bus1.rail_err, bus1.busy);
    end
    drive_start1(FIPS_SA, ~FIPS_SA, FIPS_W, ~FIPS_W, FIPS_CT, ~FIPS_CT);
    vectors++;
    if (bus1.rail_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rail_err_clear: got %b want 0", bus1.rail_err);
    end
    wait_valid1(n);
    pop_exp(et, en);
    vectors++;
    if (n != 8 || bus1.text_out !== et || bus1.text_out_n !== en) begin
      miscompares++;
      $display("FAIL rail_err_next: edges=%0d got %h/%h want 8 %h/%h",
               n, bus1.text_out, bus1.text_out_n, et, en);
    end
    ack1();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [127:0] sa, w, et, en;
    sa = rnd128(); w = rnd128();
    drive_start1(sa, ~sa, w, ~w, sa ^ w, ~(sa ^ w));
    pop_exp(et, en);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus1.busy, bus1.out_valid, bus1.rail_err, bus1.text_out, bus1.text_out_n} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: busy=%b vld=%b err=%b t=%h tn=%h want all 0",
               bus1.busy, bus1.out_valid, bus1.rail_err, bus1.text_out, bus1.text_out_n);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_start1(FIPS_SA, ~FIPS_SA, FIPS_W, ~FIPS_W, FIPS_CT, ~FIPS_CT);
    wait_valid1(n);
    pop_exp(et, en);
    vectors++;
    if (n != 8 || bus1.text_out !== et || bus1.text_out_n !== en || bus1.rail_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_restart: edges=%0d got %h/%h err=%b want 8 %h/%h err=0",
               n, bus1.text_out, bus1.text_out_n, bus1.rail_err, et, en);
    end
    ack1();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [127:0] sa, w, sb, wb, et, en;
    sa = rnd128(); w = rnd128();
    sb = rnd128(); wb = rnd128();
    drive_start1(sa, ~sa, w, ~w, sa ^ w, ~(sa ^ w));
    wait_valid1(n);
    pop_exp(et, en);
    vectors++;
    if (n != 8 || bus1.text_out !== et || bus1.text_out_n !== en) begin
      miscompares++;
      $display("FAIL b2b_first: edges=%0d got %h/%h want 8 %h/%h",
               n, bus1.text_out, bus1.text_out_n, et, en);
    end
    ack1();
    vectors++;
    if (bus1.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b want 0", bus1.busy);
    end
    drive_start1(sb, ~sb, wb, ~wb, sb ^ wb, ~(sb ^ wb));
    wait_valid1(n);
    pop_exp(et, en);
    vectors++;
    if (n != 8 || bus1.text_out !== et || bus1.text_out_n !== en) begin
      miscompares++;
      $display("FAIL b2b_second: edges=%0d got %h/%h want 8 %h/%h",
               n, bus1.text_out, bus1.text_out_n, et, en);
    end
    ack1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus1.start = 1'b0; bus1.out_ack = 1'b0;
    bus1.sa_i = '0; bus1.sa_i_n = '0; bus1.w_i = '0; bus1.w_i_n = '0;
    bus3.start = 1'b0; bus3.out_ack = 1'b0;
    bus3.sa_i = '0; bus3.sa_i_n = '0; bus3.w_i = '0; bus3.w_i_n = '0;
    test_reset();
    test_fips();
    test_pre3();
    test_hold();
    test_rail_err();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_final_xor_wddl.md
AES_FINAL_XOR_WDDL -- requirements
Module: aes_final_xor_wddl

Interface
REQ-001 Parameter PRE_CYCLES, default 1, meaning: precharge cycles inserted before each column evaluate (legal 1..3).
REQ-002 Parameter RAIL_CHECK, default 1, meaning: 1 enables dual-rail violation detection; 0 holds rail_err at 0.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to unload one block; sampled only in IDLE.
REQ-006 sa_i, sa_i_n  input  128 each  final-round state, true/complement rails.
REQ-007 w_i, w_i_n  input  128 each  last round key, true/complement rails.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 text_out, text_out_n  output  128 each  ciphertext, true/complement rails.
REQ-010 out_valid  output  1  text_out pair is complete and stable.
REQ-011 out_ack  input  1  consumer has taken text_out; meaningful only while out_valid.
REQ-012 rail_err  output  1  sticky flag: a dual-rail pair evaluated with equal rails.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, PRE, EVAL, OUT.
REQ-014 IDLE with start=1 SHALL capture sa_i, sa_i_n, w_i and w_i_n into internal registers, clear the column counter and rail_err, and go to PRE.
REQ-015 PRE SHALL last PRE_CYCLES cycles, drive the XOR operand bus to precharge (both rails 0), write nothing, then go to EVAL.
REQ-016 EVAL SHALL last one cycle and write column col of the captured state XOR the captured key into text_out/text_out_n; the rail pair is computed by a dual-rail XOR.
REQ-017 Column col=0 SHALL map to bits [127:96] and col=3 to bits [31:0].
REQ-018 After EVAL with col<3, the FSM SHALL increment col and go to PRE; after EVAL with col=3, it SHALL go to OUT.
REQ-019 out_valid SHALL be high exactly while in OUT, beginning 4*(PRE_CYCLES+1) clock edges after the start-sampling edge (8 with the default).
REQ-020 In OUT, text_out/text_out_n SHALL hold constant until out_ack=1 is sampled.
REQ-021 On out_ack in OUT, the FSM SHALL clear all text_out/text_out_n bits to 0 (precharge) and go to IDLE.
REQ-022 start SHALL be ignored outside IDLE.
REQ-023 out_ack SHALL be ignored outside OUT.
REQ-024 start asserted in the IDLE cycle immediately after an ack SHALL be accepted normally.
REQ-025 With RAIL_CHECK=1, rail_err SHALL be set in an EVAL cycle when any of the 32 captured sa or w pairs of the current column has true rail equal to complement rail.
REQ-026 rail_err SHALL remain set until the next accepted start or reset.
REQ-027 An operation with rail_err set SHALL still complete normally.
REQ-028 Unwritten columns of text_out SHALL remain 0/0 during an operation.

Reset
REQ-029 Asserting rst SHALL immediately force: state IDLE; col 0; busy, out_valid and rail_err 0; text_out and text_out_n all 0; capture registers all 0.
REQ-030 Reset asserted mid-operation (PRE, EVAL or OUT) SHALL abort with no partial output retained.
REQ-031 After rst deasserts, the first start SHALL behave as from power-up.

Structure
REQ-032 The shared package aes_wddl_pkg SHALL hold the FSM state typedef, COL_W=32, NUM_COLS=4 and the column-index type.
REQ-033 The dual-rail XOR SHALL be the existing wddl_xor2 cell, instantiated 32 wide on the column-selected operands; no other sub-module.

Verification
REQ-034 FIPS-197 App. B: sa=e9317db5cb322c723d2e895faf090794 (n = bitwise inverse), w=d014f9a8c9ee2589e13f0cc8b6630ca6 -> 8 cycles after start, out_valid=1, text_out=3925841d02dc09fbdc118597196a0b32, text_out_n = its inverse, rail_err=0.
REQ-035 PRE_CYCLES=3, same vectors -> out_valid exactly 16 edges after start; intermediate snapshots show only completed columns non-zero.
REQ-036 out_ack held low 20 cycles, start pulsed during OUT -> outputs stable, start ignored; ack -> next cycle IDLE, all outputs 0/0.
REQ-037 sa_i bit 70 with sa_i = sa_i_n = 1 -> rail_err rises at EVAL of col 1 (after PRE), stays set through OUT, clears on the next start.
REQ-038 rst pulsed during EVAL of col 2 -> outputs 0 asynchronously; subsequent clean start yields the REQ-034 result.
REQ-039 Back-to-back: ack and start in consecutive cycles with two different vectors -> both results correct, no column carry-over.
